// File: rtl/modn_counter_if.sv
// Control and status bundle for modn_counter.
// The master drives the controls; the slave (the counter) drives the status.
interface modn_counter_if #(
  parameter int WIDTH  = 2,
  parameter int WRAP_W = 4
);
  logic              en;
  logic              dir;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_wraps;
  logic [WIDTH-1:0]  count;
  logic              y;
  logic              tc;
  logic              div_out;
  logic              load_err;
  logic [WRAP_W-1:0] wraps;

  modport master (
    output en, dir, load, load_val, clr_wraps,
    input  count, y, tc, div_out, load_err, wraps
  );

  modport slave (
    input  en, dir, load, load_val, clr_wraps,
    output count, y, tc, div_out, load_err, wraps
  );
endinterface

// File: rtl/modn_counter.sv
// Programmable modulo-N up/down counter with load, terminal-count strobe,
// registered divided waveform and a saturating wrap counter.
module modn_counter #(
  parameter int MOD      = 3,
  parameter int WIDTH    = 2,
  parameter int HIGH_CNT = 1,
  parameter int WRAP_W   = 4
) (
  input  logic          clk,
  input  logic          reset,
  modn_counter_if.slave bus
);

  if (MOD < 1 || (2 ** WIDTH) < MOD || HIGH_CNT > MOD) begin : g_param_check
    $fatal(1, "modn_counter: illegal MOD/WIDTH/HIGH_CNT combination");
  end

  localparam logic [WIDTH-1:0] CNT_MAX = WIDTH'(MOD - 1);
  // One extra bit so MOD and HIGH_CNT can equal 2**WIDTH without truncation.
  localparam logic [WIDTH:0]   MOD_W   = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH:0]   HIGH_W  = (WIDTH + 1)'(HIGH_CNT);

  logic [WIDTH-1:0]  r_count;
  logic              r_load_err;
  logic              r_div_out;
  logic [WRAP_W-1:0] r_wraps;

  logic [WIDTH-1:0]  w_count_next;
  logic              w_load_err_next;
  logic              w_at_max;
  logic              w_at_zero;
  logic              w_tc;

  assign w_at_max  = (r_count == CNT_MAX);
  assign w_at_zero = (r_count == '0);
  assign w_tc      = bus.en & ~bus.load & ~reset & (bus.dir ? w_at_max : w_at_zero);

  always_comb begin
    w_count_next    = r_count;
    w_load_err_next = 1'b0;
    if (bus.load) begin
      if ({1'b0, bus.load_val} < MOD_W) begin
        w_count_next = bus.load_val;
      end else begin
        w_count_next    = '0;
        w_load_err_next = 1'b1;
      end
    end else if (bus.en) begin
      if (bus.dir) begin
        w_count_next = w_at_max ? '0 : r_count + WIDTH'(1);
      end else begin
        w_count_next = w_at_zero ? CNT_MAX : r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_load_err <= 1'b0;
      r_div_out  <= (HIGH_CNT > 0);
      r_wraps    <= '0;
    end else begin
      r_count    <= w_count_next;
      r_load_err <= w_load_err_next;
      // Decoded from the next count so div_out tracks count with no comb path.
      r_div_out  <= ({1'b0, w_count_next} < HIGH_W);
      if (bus.clr_wraps) begin
        r_wraps <= '0;
      end else if (w_tc && (r_wraps != '1)) begin
        r_wraps <= r_wraps + WRAP_W'(1);
      end
    end
  end

  assign bus.count    = r_count;
  assign bus.y        = (r_count == '0);
  assign bus.tc       = w_tc;
  assign bus.div_out  = r_div_out;
  assign bus.load_err = r_load_err;
  assign bus.wraps    = r_wraps;

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboarded bench for modn_counter: MOD=3 main instance plus WRAP_W=2
// and MOD=1 instances for saturation and degenerate-modulus behaviour.
module tb_modn_counter;

  logic clk = 1'b0;
  logic reset;
  logic reset_bm;

  always #5 clk = ~clk;

  modn_counter_if #(.WIDTH(2), .WRAP_W(4)) bus_a ();
  modn_counter_if #(.WIDTH(2), .WRAP_W(2)) bus_b ();
  modn_counter_if #(.WIDTH(1), .WRAP_W(4)) bus_m ();

  modn_counter #(.MOD(3), .WIDTH(2), .HIGH_CNT(1), .WRAP_W(4)) u_dut_a (
    .clk(clk), .reset(reset), .bus(bus_a.slave));
  modn_counter #(.MOD(3), .WIDTH(2), .HIGH_CNT(1), .WRAP_W(2)) u_dut_b (
    .clk(clk), .reset(reset_bm), .bus(bus_b.slave));
  modn_counter #(.MOD(1), .WIDTH(1), .HIGH_CNT(1), .WRAP_W(4)) u_dut_m (
    .clk(clk), .reset(reset_bm), .bus(bus_m.slave));

  typedef struct {
    int count;
    int y;
    int div_out;
    int load_err;
    int wraps;
  } exp_t;

  exp_t sb_q[$];
  int   m_count;
  int   m_wraps;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle on the main instance, predict the post-edge state,
  // then compare what the DUT produced against the oldest prediction.
  task automatic step(input bit rst, input bit en, input bit dir,
                      input bit ld, input int lv, input bit clr);
    exp_t e;
    exp_t got;
    bit   tc_exp;
    int   err;
    reset          = rst;
    bus_a.en       = en;
    bus_a.dir      = dir;
    bus_a.load     = ld;
    bus_a.load_val = 2'(lv);
    bus_a.clr_wraps = clr;
    #1;
    tc_exp = en && !ld && !rst && (dir ? (m_count == 2) : (m_count == 0));
    chk("tc", int'(bus_a.tc), int'(tc_exp));
    if (rst) begin
      m_count = 0;
      m_wraps = 0;
      err     = 0;
    end else begin
      err = 0;
      if (ld) begin
        if (lv < 3) m_count = lv;
        else begin
          m_count = 0;
          err     = 1;
        end
      end else if (en) begin
        if (dir) m_count = (m_count + 1) % 3;
        else     m_count = (m_count + 2) % 3;
      end
      if (clr) m_wraps = 0;
      else if (tc_exp && m_wraps < 15) m_wraps++;
    end
    e.count    = m_count;
    e.y        = (m_count == 0);
    e.div_out  = (m_count < 1);
    e.load_err = err;
    e.wraps    = m_wraps;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    chk("count",    int'(bus_a.count),    got.count);
    chk("y",        int'(bus_a.y),        got.y);
    chk("div_out",  int'(bus_a.div_out),  got.div_out);
    chk("load_err", int'(bus_a.load_err), got.load_err);
    chk("wraps",    int'(bus_a.wraps),    got.wraps);
  endtask

  task automatic step_bm(input bit rst, input bit en, input bit clr);
    reset_bm        = rst;
    bus_b.en        = en;
    bus_b.clr_wraps = clr;
    bus_m.en        = en;
    bus_m.clr_wraps = clr;
    #1;
    chk("m_tc", int'(bus_m.tc), int'(en && !rst));
    @(posedge clk);
    #1;
    chk("m_count", int'(bus_m.count), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc;
    int bw;
    int mw;
    bit tcb;
    m_count  = 0;
    m_wraps  = 0;
    reset    = 1'b1;
    reset_bm = 1'b1;
    bus_b.dir = 1'b1; bus_b.load = 1'b0; bus_b.load_val = '0;
    bus_b.en  = 1'b0; bus_b.clr_wraps = 1'b0;
    bus_m.dir = 1'b1; bus_m.load = 1'b0; bus_m.load_val = '0;
    bus_m.en  = 1'b0; bus_m.clr_wraps = 1'b0;

    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("rst_count", int'(bus_a.count), 0);
    chk("rst_div", int'(bus_a.div_out), 1);

    // Up count, 7 cycles: two wraps.
    for (int i = 0; i < 7; i++) step(0, 1, 1, 0, 0, 0);
    chk("up_wraps", int'(bus_a.wraps), 2);

    // Down count from 0.
    step(0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 0);
    chk("down_count", int'(bus_a.count), 2);

    // Loads: in-range, out-of-range, then flag drops.
    step(0, 0, 1, 1, 2, 0);
    chk("load2", int'(bus_a.count), 2);
    step(0, 0, 1, 1, 3, 0);
    chk("load3_err", int'(bus_a.load_err), 1);
    step(0, 0, 1, 0, 0, 0);
    chk("err_clear", int'(bus_a.load_err), 0);

    // Load beats enable at count==2: no tc, wraps unchanged.
    step(0, 0, 1, 1, 2, 0);
    step(0, 1, 1, 1, 1, 0);
    chk("load_en_count", int'(bus_a.count), 1);

    // Reset mid-operation with wraps=5 and count=2.
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(0, 1, 1, 0, 0, 0);
    chk("pre_rst_wraps", int'(bus_a.wraps), 5);
    chk("pre_rst_count", int'(bus_a.count), 2);
    step(1, 1, 1, 0, 0, 0);
    chk("mid_rst_wraps", int'(bus_a.wraps), 0);

    // clr_wraps together with tc.
    for (int i = 0; i < 5; i++) step(0, 1, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0, 1);
    chk("clr_tc_wraps", int'(bus_a.wraps), 0);

    // Random mix of all controls.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 19) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0), $urandom_range(0, 3), ($urandom_range(0, 7) == 0));
    end

    // WRAP_W=2 saturation and MOD=1 behaviour.
    step_bm(1, 0, 0);
    bc = 0; bw = 0; mw = 0;
    for (int i = 0; i < 15; i++) begin
      tcb = (bc == 2);
      step_bm(0, 1, 0);
      bc = (bc + 1) % 3;
      if (tcb && bw < 3) bw++;
      if (mw < 15) mw++;
      chk("b_count", int'(bus_b.count), bc);
      chk("b_wraps", int'(bus_b.wraps), bw);
      chk("m_wraps", int'(bus_m.wraps), mw);
    end
    chk("b_sat", int'(bus_b.wraps), 3);
    step_bm(0, 1, 0);
    step_bm(0, 1, 0);
    chk("b_count2", int'(bus_b.count), 2);
    step_bm(0, 1, 1);
    chk("b_clr_wraps", int'(bus_b.wraps), 0);
    chk("b_clr_count", int'(bus_b.count), 0);
    chk("m_clr_wraps", int'(bus_m.wraps), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
